axi_m_rd_sched: RTL
===================

# axi_m_rd_sched

Round-robin job scheduler in front of a single AXI4 read engine (ctrl_start/ctrl_offset/ctrl_size/ctrl_done interface). It accepts read descriptors (byte offset, beat count) from C_NUM_REQ requesters, grants one at a time, and sequences the engine through start/done. It tags the job in flight so downstream stream logic can route data, and returns a per-requester completion pulse. Zero-length jobs complete locally without touching the engine.

## Interface
- C_NUM_REQ, 4, number of requesters (2..16)
- C_ADDR_W, 64, descriptor offset width
- C_SIZE_W, 32, descriptor size width (beats)
- C_ID_W, $clog2(C_NUM_REQ), width of job tag
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- req_valid_i  in  C_NUM_REQ  descriptor valid per requester
- req_ready_o  out  C_NUM_REQ  descriptor accepted (one-hot or zero)
- req_offset_i  in  C_NUM_REQ*C_ADDR_W  packed offsets, requester i at [i*C_ADDR_W +: C_ADDR_W]
- req_size_i  in  C_NUM_REQ*C_SIZE_W  packed sizes, same packing
- req_done_o  out  C_NUM_REQ  one-cycle completion pulse to owning requester
- eng_start_o  out  1  one-cycle engine start pulse
- eng_offset_o  out  C_ADDR_W  engine offset, stable from start until done
- eng_size_o  out  C_SIZE_W  engine size, stable from start until done
- eng_done_i  in  1  engine completion pulse
- job_id_o  out  C_ID_W  requester index of current or last job
- busy_o  out  1  job in flight (state != IDLE)
- jobs_done_o  out  32  completed job count, wraps

## Operation
- FSM states: IDLE, START, BUSY, DONE.
- IDLE: if any req_valid_i, select winner by round-robin. Search begins at index ptr, where ptr = (last granted + 1) mod C_NUM_REQ; ptr = 0 after reset.
  - In the same cycle, assert req_ready_o[winner] (combinational from req_valid_i and state).
  - Latch offset, size, and winner into job_id.
  - Next state is START if size != 0, otherwise DONE.
  - Update ptr to winner+1 mod C_NUM_REQ.
- START: eng_start_o = 1 for exactly this cycle; next state BUSY.
- BUSY: wait for eng_done_i; on it, go to DONE.
- DONE: req_done_o[job_id] = 1 for this cycle; increment jobs_done_o; next state IDLE.
- eng_done_i outside BUSY is ignored (no state change, no counter change).
- req_ready_o is all-zero outside IDLE. A requester holds valid and descriptor until ready.
- eng_offset_o/eng_size_o come from the latched registers and change only on accept.
- job_id_o holds after DONE until the next accept.
- Arithmetic: ptr wraps modulo C_NUM_REQ; non-power-of-2 C_NUM_REQ is supported; jobs_done_o wraps 0xFFFFFFFF→0.

## Timing
- Reset values: all outputs 0, state IDLE, ptr 0.
- Reset mid-job: immediately return to IDLE; no done pulse; the engine shares rst_n.
- Accept at cycle t → eng_start_o at t+1 → BUSY from t+2.
- eng_done_i at cycle u (in BUSY) → req_done_o at u+1 → IDLE at u+2. Earliest next accept is at u+2.
- Zero-size accept at t → req_done_o at t+1, no eng_start_o.
- Minimum non-zero job occupancy: accept to next accept = 4 cycles plus engine latency.
- Requester deasserting valid before ready: no job is created; the arbiter re-evaluates each IDLE cycle.
- Simultaneous requests: exactly one ready per accept. No requester waits more than C_NUM_REQ−1 grants while valid.

## Test plan
- Single job: req 2 valid with offset 0x1000, size 300 → req_ready_o=0b0100 at t; eng_start_o at t+1 with offset 0x1000, size 300; eng_done_i at u → req_done_o=0b0100 at u+1; jobs_done_o=1.
- Round-robin fairness (C_NUM_REQ=4): all valid continuously, engine done 5 cycles after each start → grant order 0,1,2,3,0,1; every req_done_o routed to the matching index.
- Zero-size job: req 1 with size 0 → ready at t, req_done_o[1] at t+1, eng_start_o never asserted, jobs_done_o increments.
- Spurious done: pulse eng_done_i in IDLE and in START → no req_done_o, no counter change; the real done in BUSY completes normally.
- Reset mid-BUSY: rst_n low for 1 cycle → all outputs 0, ptr 0. The next grant with req 0 and 3 both valid goes to 0.
- Counter wrap plus non-power-of-2 (C_NUM_REQ=3): preload jobs_done_o near 0xFFFFFFFF via repeated zero-size jobs (force) → wraps to 0; grant order 0,1,2,0.

Source files
------------

// File: rtl/axi_m_rd_sched.sv
// Round-robin scheduler that feeds read descriptors from several requesters
// into a single AXI4 read engine and routes the completion back to the owner.
module axi_m_rd_sched #(
    parameter int C_NUM_REQ = 4,
    parameter int C_ADDR_W  = 64,
    parameter int C_SIZE_W  = 32,
    parameter int C_ID_W    = $clog2(C_NUM_REQ)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [C_NUM_REQ-1:0]            req_valid_i,
    output logic [C_NUM_REQ-1:0]            req_ready_o,
    input  logic [C_NUM_REQ*C_ADDR_W-1:0]   req_offset_i,
    input  logic [C_NUM_REQ*C_SIZE_W-1:0]   req_size_i,
    output logic [C_NUM_REQ-1:0]            req_done_o,
    output logic                            eng_start_o,
    output logic [C_ADDR_W-1:0]             eng_offset_o,
    output logic [C_SIZE_W-1:0]             eng_size_o,
    input  logic                            eng_done_i,
    output logic [C_ID_W-1:0]               job_id_o,
    output logic                            busy_o,
    output logic [31:0]                     jobs_done_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_BUSY  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [C_ID_W-1:0]      ptr_q, ptr_d;
    logic [C_ID_W-1:0]      job_id_q, job_id_d;
    logic [C_ADDR_W-1:0]    offset_q, offset_d;
    logic [C_SIZE_W-1:0]    size_q, size_d;
    logic [31:0]            jobs_done_q, jobs_done_d;
    logic                   start_q, start_d;
    logic                   busy_q, busy_d;
    logic [C_NUM_REQ-1:0]   done_q, done_d;

    logic                   found_s;
    logic                   accept_s;
    logic [C_ID_W-1:0]      winner_s;
    logic [C_NUM_REQ-1:0]   grant_s;
    logic [C_ADDR_W-1:0]    win_offset_s;
    logic [C_SIZE_W-1:0]    win_size_s;

    // (base + k) mod C_NUM_REQ for k < C_NUM_REQ; works for any requester count.
    function automatic logic [C_ID_W-1:0] rr_idx(input logic [C_ID_W-1:0] base, input int k);
        int sum;
        sum = 32'(base) + k;
        if (sum >= C_NUM_REQ) begin
            sum = sum - C_NUM_REQ;
        end else begin
            sum = sum;
        end
        return C_ID_W'(sum);
    endfunction

    function automatic logic [C_NUM_REQ-1:0] one_hot(input logic [C_ID_W-1:0] idx);
        return {{(C_NUM_REQ-1){1'b0}}, 1'b1} << idx;
    endfunction

    // Round-robin arbitration: first valid requester at or after ptr_q.
    always_comb begin
        found_s  = 1'b0;
        winner_s = '0;
        for (int k = 0; k < C_NUM_REQ; k++) begin
            if (!found_s && req_valid_i[rr_idx(ptr_q, k)]) begin
                found_s  = 1'b1;
                winner_s = rr_idx(ptr_q, k);
            end else begin
                found_s  = found_s;
            end
        end
    end

    assign accept_s     = rst_n && (state_q == S_IDLE) && found_s;
    assign grant_s      = accept_s ? one_hot(winner_s) : '0;
    assign win_offset_s = req_offset_i[winner_s*C_ADDR_W +: C_ADDR_W];
    assign win_size_s   = req_size_i[winner_s*C_SIZE_W +: C_SIZE_W];

    // Job sequencing and next values for every registered output.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        job_id_d    = job_id_q;
        offset_d    = offset_q;
        size_d      = size_q;
        jobs_done_d = jobs_done_q;
        case (state_q)
            S_IDLE: begin
                if (accept_s) begin
                    job_id_d = winner_s;
                    offset_d = win_offset_s;
                    size_d   = win_size_s;
                    ptr_d    = rr_idx(winner_s, 1);
                    // Zero-length jobs complete locally and never start the engine.
                    if (win_size_s != {C_SIZE_W{1'b0}}) begin
                        state_d = S_START;
                    end else begin
                        state_d = S_DONE;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START: state_d = S_BUSY;
            S_BUSY: begin
                if (eng_done_i) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_BUSY;
                end
            end
            S_DONE: begin
                state_d     = S_IDLE;
                jobs_done_d = jobs_done_q + 32'd1;
            end
            default: state_d = S_IDLE;
        endcase

        start_d = (state_d == S_START);
        busy_d  = (state_d != S_IDLE);
        if (state_d == S_DONE) begin
            done_d = one_hot(job_id_d);
        end else begin
            done_d = '0;
        end
    end

    // State and output registers; the engine shares this reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            job_id_q    <= '0;
            offset_q    <= '0;
            size_q      <= '0;
            jobs_done_q <= 32'd0;
            start_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            job_id_q    <= job_id_d;
            offset_q    <= offset_d;
            size_q      <= size_d;
            jobs_done_q <= jobs_done_d;
            start_q     <= start_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign req_ready_o  = grant_s;
    assign req_done_o   = done_q;
    assign eng_start_o  = start_q;
    assign eng_offset_o = offset_q;
    assign eng_size_o   = size_q;
    assign job_id_o     = job_id_q;
    assign busy_o       = busy_q;
    assign jobs_done_o  = jobs_done_q;

endmodule
